// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority vote per bit,
// level-valid/ack byte handshake, framing-error pulse and sticky overrun.
module uart_byte_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mosi,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rok,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV_RAW = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TCW-1:0] TC_MAX = TCW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t         state, state_nx;
    logic           s1, rxs;
    logic [TCW-1:0] tc;
    logic [3:0]     sc;
    logic [2:0]     bc;
    logic           v_a, v_b;
    logic [7:0]     sr;

    logic tick, start_det, vote_now, wrap, vote, byte_done, fe_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b1;
            rxs <= 1'b1;
        end else begin
            s1  <= mosi;
            rxs <= s1;
        end
    end

    assign tick      = (tc == TC_MAX);
    assign start_det = (state == IDLE) && !rxs;
    // Samples land on the 7th, 8th and 9th tick of each bit, centred on mid-bit.
    assign vote_now  = tick && (sc == 4'd8);
    assign wrap      = tick && (sc == 4'd15);
    assign vote      = (v_a & v_b) | (v_a & rxs) | (v_b & rxs);
    assign byte_done = (state == STOP) && vote_now && vote;
    assign fe_now    = (state == STOP) && vote_now && !vote;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (!rxs) state_nx = START;
            START: begin
                if (vote_now && vote) state_nx = IDLE;
                else if (wrap)        state_nx = DATA;
            end
            DATA:  if (wrap && (bc == 3'd7)) state_nx = STOP;
            // Leave at the stop-bit vote so the next start edge finds us idle.
            STOP:  if (vote_now) state_nx = vote ? IDLE : BRK;
            BRK:   if (rxs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc  <= '0;
            sc  <= '0;
            bc  <= '0;
            v_a <= 1'b0;
            v_b <= 1'b0;
            sr  <= '0;
        end else begin
            if (start_det || tick) tc <= '0;
            else                   tc <= tc + TCW'(1);

            if (start_det) sc <= '0;
            else if (tick) sc <= sc + 4'd1;

            if (state == START && wrap)     bc <= '0;
            else if (state == DATA && wrap) bc <= bc + 3'd1;

            if (tick && sc == 4'd6) v_a <= rxs;
            if (tick && sc == 4'd7) v_b <= rxs;

            if (state == DATA && vote_now) sr <= {vote, sr[7:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= '0;
            rok       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= fe_now;
            if (byte_done) rx_data <= sr;

            if (byte_done)      rok <= 1'b1;
            else if (rd && rok) rok <= 1'b0;

            // A same-cycle ack consumes the old byte, so that case is not an overrun.
            if (byte_done && rok && !rd) overrun <= 1'b1;
            else if (rd && rok)          overrun <= 1'b0;
        end
    end
endmodule
